branch_redirect_ctrl: RTL

Branch prediction and redirect controller for the RV32I pipeline. It gives fetch a prediction from a direct-mapped table of 2-bit counters and branch targets. It consumes the execute-stage branch resolution (the `branch_taken` result of the branch unit) and trains the table. On a misprediction it issues a one-cycle PC redirect and holds a pipeline flush for a fixed number of cycles.

---
 rtl/branch_redirect_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
//  Module   : branch_redirect_ctrl
//  Brief    : Direct-mapped 2-bit branch predictor with mispredict redirect
//             and fixed-length pipeline flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_redirect_ctrl #(
    parameter int IDX_BITS     = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int c_ENTRIES = 1 << IDX_BITS;
    localparam int c_TAG_W   = 32 - IDX_BITS - 2;
    localparam int c_CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_FLUSH_LOAD = c_CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic               r_valid  [c_ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [c_ENTRIES];
    logic [1:0]         r_ctr    [c_ENTRIES];
    logic [31:0]        r_target [c_ENTRIES];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_fcnt;
    logic [c_CNT_W-1:0] w_fcnt_nxt;

    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_flush;
    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [c_TAG_W-1:0]  w_if_tag;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [c_TAG_W-1:0]  w_ex_tag;
    logic                w_ex_hit;
    logic [1:0]          w_ctr_nxt;
    logic                w_resolve;
    logic                w_mispredict;
    logic                w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch-side lookup reads the array directly, so a same-cycle training
    // write is only seen from the next cycle on.
    assign w_if_idx    = if_pc[IDX_BITS+1:2];
    assign w_if_tag    = if_pc[31:IDX_BITS+2];
    assign pred_taken  = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag) & r_ctr[w_if_idx][1];
    assign pred_target = r_target[w_if_idx];

    assign w_ex_idx     = ex_pc[IDX_BITS+1:2];
    assign w_ex_tag     = ex_pc[31:IDX_BITS+2];
    assign w_ex_hit     = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
    assign w_resolve    = ex_valid & ex_is_branch & (r_state == ST_RUN);
    assign w_mispredict = w_resolve &
                          ((ex_branch_taken != ex_pred_taken) |
                           (ex_branch_taken & ex_pred_taken & (ex_pred_target != ex_target)));

    always_comb begin
        w_ctr_nxt = r_ctr[w_ex_idx];
        if (!w_ex_hit) begin
            w_ctr_nxt = ex_branch_taken ? 2'b10 : 2'b01;
        end else if (ex_branch_taken) begin
            if (r_ctr[w_ex_idx] != 2'b11) w_ctr_nxt = r_ctr[w_ex_idx] + 2'b01;
        end else begin
            if (r_ctr[w_ex_idx] != 2'b00) w_ctr_nxt = r_ctr[w_ex_idx] - 2'b01;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_RUN: begin
                if (w_mispredict) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = c_FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'b01;
                r_target[i] <= '0;
            end
            r_redirect         <= 1'b0;
            r_redirect_pc      <= '0;
            r_flush            <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_redirect <= w_mispredict;
            r_flush    <= (w_state_nxt == ST_FLUSH);
            if (w_resolve) begin
                r_valid[w_ex_idx] <= 1'b1;
                r_tag[w_ex_idx]   <= w_ex_tag;
                r_ctr[w_ex_idx]   <= w_ctr_nxt;
                if (ex_branch_taken) r_target[w_ex_idx] <= ex_target;
                if (r_branch_count != 32'hFFFF_FFFF) r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict) begin
                r_redirect_pc <= ex_branch_taken ? ex_target : (ex_pc + 32'd4);
                if (r_mispredict_count != 32'hFFFF_FFFF) r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign redirect         = r_redirect;
    assign redirect_pc      = r_redirect_pc;
    assign flush            = r_flush;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire
